// File: rtl/mbldcm_ramp_master_if.sv
// rtl/mbldcm_ramp_master_if.sv - Avalon-MM bundle between the ramp master and the BLDC controller slave
interface mbldcm_ramp_master_if;
    logic [1:0]  addr;
    logic        read;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        waitrequest;

    modport master (
        output addr, read, write, wdata,
        input  rdata, resp, waitrequest
    );

    modport slave (
        input  addr, read, write, wdata,
        output rdata, resp, waitrequest
    );
endinterface

// File: rtl/mbldcm_ramp_master.sv
// rtl/mbldcm_ramp_master.sv - Avalon-MM master that ramps the BLDC controller frequency toward a goal
// Each step writes the frequency-target register, then polls status until the value is reflected.
module mbldcm_ramp_master #(
    parameter logic [1:0]  pFreqAddr  = 2'd1,
    parameter logic [1:0]  pStatAddr  = 2'd0,
    parameter logic [4:0]  pReflBit   = 5'd1,
    parameter logic [31:0] pPollLimit = 32'd1024
) (
    input  logic                 iClock,
    input  logic                 iReset_n,
    input  logic                 iStart,
    input  logic                 iAbort,
    input  logic [31:0]          iFreqGoal,
    input  logic [31:0]          iStep,
    input  logic [31:0]          iInterval,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oError,
    output logic [31:0]          oFreqNow,
    mbldcm_ramp_master_if.master bus
);

    typedef enum logic [2:0] {
        sIdle  = 3'd0,
        sWait  = 3'd1,
        sCalc  = 3'd2,
        sWrite = 3'd3,
        sPoll  = 3'd4,
        sDone  = 3'd5,
        sErr   = 3'd6
    } tState;

    tState       state;
    tState       nextState;

    logic [31:0] goal;
    logic [31:0] step;
    logic [31:0] interval;
    logic [31:0] freqNext;
    logic [31:0] calcNext;
    logic [31:0] intervalCnt;
    logic [31:0] pollCnt;
    logic        abortPend;
    logic        pollGap;

    logic        readQ;
    logic        writeQ;
    logic [1:0]  addrQ;
    logic [31:0] wdataQ;

    logic        readNxt;
    logic        writeNxt;
    logic [1:0]  addrNxt;
    logic        busyNxt;
    logic        doneNxt;
    logic        gapNxt;

    logic        startOk;
    logic        abortSeen;
    logic        writeDone;
    logic        readDone;
    logic        respErr;
    logic        reflected;
    logic        pollExhausted;
    logic [32:0] sumWide;
    logic [32:0] diffWide;
    logic        unusedRdata;

    assign bus.read  = readQ;
    assign bus.write = writeQ;
    assign bus.addr  = addrQ;
    assign bus.wdata = wdataQ;

    assign startOk       = (state == sIdle) && iStart && !iAbort;
    assign abortSeen     = abortPend || iAbort;
    assign writeDone     = writeQ && !bus.waitrequest;
    assign readDone      = readQ && !bus.waitrequest;
    assign respErr       = (bus.resp != 2'b00);
    assign reflected     = bus.rdata[pReflBit];
    assign pollExhausted = ((pollCnt + 32'd1) >= pPollLimit);
    assign unusedRdata   = ^bus.rdata;

    // 33-bit arithmetic so a carry or borrow clamps to the goal instead of wrapping.
    assign sumWide  = {1'b0, oFreqNow} + {1'b0, step};
    assign diffWide = {1'b0, oFreqNow} - {1'b0, step};

    always_comb begin
        calcNext = goal;
        if (oFreqNow < goal) begin
            if (!sumWide[32] && (sumWide[31:0] < goal)) begin
                calcNext = sumWide[31:0];
            end
        end else begin
            if (!diffWide[32] && (diffWide[31:0] > goal)) begin
                calcNext = diffWide[31:0];
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state   <= sIdle;
            readQ   <= 1'b0;
            writeQ  <= 1'b0;
            addrQ   <= 2'd0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            pollGap <= 1'b0;
        end else begin
            state   <= nextState;
            readQ   <= readNxt;
            writeQ  <= writeNxt;
            addrQ   <= addrNxt;
            oBusy   <= busyNxt;
            oDone   <= doneNxt;
            pollGap <= gapNxt;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            sIdle: begin
                if (startOk) begin
                    nextState = (iFreqGoal == oFreqNow) ? sDone : sCalc;
                end
            end
            sCalc: begin
                nextState = iAbort ? sIdle : sWrite;
            end
            sWrite: begin
                if (writeDone) begin
                    if (respErr) begin
                        nextState = sErr;
                    end else if (abortSeen) begin
                        nextState = sIdle;
                    end else begin
                        nextState = sPoll;
                    end
                end
            end
            sPoll: begin
                if (pollGap) begin
                    if (abortSeen) begin
                        nextState = sIdle;
                    end
                end else if (readDone) begin
                    if (respErr) begin
                        nextState = sErr;
                    end else if (reflected) begin
                        if (abortSeen) begin
                            nextState = sIdle;
                        end else if (freqNext == goal) begin
                            nextState = sDone;
                        end else begin
                            nextState = sWait;
                        end
                    end else if (pollExhausted) begin
                        nextState = sErr;
                    end else if (abortSeen) begin
                        nextState = sIdle;
                    end
                end
            end
            sWait: begin
                if (iAbort) begin
                    nextState = sIdle;
                end else if (intervalCnt == 32'd0) begin
                    nextState = sCalc;
                end
            end
            sDone:   nextState = sIdle;
            sErr:    nextState = sIdle;
            default: nextState = sIdle;
        endcase
    end

    // Bus and status outputs are decoded from the next state so they leave a flop directly.
    always_comb begin
        writeNxt = (nextState == sWrite);
        gapNxt   = (state == sPoll) && readDone && (nextState == sPoll);
        readNxt  = (nextState == sPoll) && !gapNxt;
        addrNxt  = 2'd0;
        if (nextState == sWrite) begin
            addrNxt = pFreqAddr;
        end else if (nextState == sPoll) begin
            addrNxt = pStatAddr;
        end
        busyNxt  = (nextState == sCalc) || (nextState == sWrite) ||
                   (nextState == sPoll) || (nextState == sWait);
        doneNxt  = (nextState == sDone);
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            goal        <= 32'd0;
            step        <= 32'd0;
            interval    <= 32'd0;
            freqNext    <= 32'd0;
            intervalCnt <= 32'd0;
            pollCnt     <= 32'd0;
            abortPend   <= 1'b0;
            wdataQ      <= 32'd0;
            oError      <= 1'b0;
            oFreqNow    <= 32'd0;
        end else begin
            if (startOk) begin
                goal     <= iFreqGoal;
                step     <= (iStep == 32'd0) ? 32'd1 : iStep;
                interval <= iInterval;
            end

            if (nextState == sErr) begin
                oError <= 1'b1;
            end else if (startOk) begin
                oError <= 1'b0;
            end

            if (state == sCalc) begin
                freqNext <= calcNext;
                wdataQ   <= calcNext;
            end

            if ((state == sWrite) && writeDone) begin
                pollCnt <= 32'd0;
            end else if ((state == sPoll) && readDone && !respErr && !reflected) begin
                pollCnt <= pollCnt + 32'd1;
            end

            if ((state == sPoll) && readDone && !respErr && reflected) begin
                oFreqNow <= freqNext;
            end

            if ((nextState == sWait) && (state != sWait)) begin
                intervalCnt <= interval;
            end else if ((state == sWait) && (intervalCnt != 32'd0)) begin
                intervalCnt <= intervalCnt - 32'd1;
            end

            // An abort during a transfer is held until that transfer completes.
            if ((state == sWrite) || (state == sPoll)) begin
                if (iAbort) begin
                    abortPend <= 1'b1;
                end
            end else begin
                abortPend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mbldcm_ramp_master.sv
// tb/tb_mbldcm_ramp_master.sv - self-checking bench for mbldcm_ramp_master with a reactive slave model
module tb_mbldcm_ramp_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [31:0] freqGoal;
    logic [31:0] stepIn;
    logic [31:0] intervalIn;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] freqNow;

    mbldcm_ramp_master_if av();

    mbldcm_ramp_master #(.pPollLimit(32'd8)) dut (
        .iClock   (clk),
        .iReset_n (rstn),
        .iStart   (start),
        .iAbort   (abort),
        .iFreqGoal(freqGoal),
        .iStep    (stepIn),
        .iInterval(intervalIn),
        .oBusy    (busy),
        .oDone    (done),
        .oError   (error),
        .oFreqNow (freqNow),
        .bus      (av)
    );

    always #5 clk = ~clk;

    int          nCompared = 0;
    int          nMismatch = 0;
    int          cyc = 0;
    int          startCyc = 0;
    int          firstWriteCyc = -1;
    int          readCount = 0;
    int          doneCount = 0;
    int          writeIdx = 0;
    int          errWriteIdx = -1;
    int          cfgFails = 0;
    int          failLeft = 0;
    int          cfgWriteStall = 0;
    int          stallLeft = 0;
    logic        prevStall = 1'b0;
    logic [31:0] prevWdata = 32'd0;
    logic [31:0] gotWrites[$];
    logic [31:0] expWrites[$];
    longint      modelFreq = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: answers at the negative edge so its response is stable for the next rising edge.
    initial begin
        av.waitrequest = 1'b0;
        av.resp        = 2'b00;
        av.rdata       = 32'd0;
        forever begin
            @(negedge clk);
            av.waitrequest = 1'b0;
            av.resp        = 2'b00;
            av.rdata       = 32'd0;
            if (!rstn) begin
                prevStall = 1'b0;
            end else begin
                if (av.read || av.write) begin
                    nCompared++;
                    if (av.read && av.write) begin
                        nMismatch++;
                        $display("FAIL bus_exclusive: read=%0b write=%0b, required not both", av.read, av.write);
                    end
                end
                if (prevStall) begin
                    nCompared++;
                    if (av.write !== 1'b1 || av.wdata !== prevWdata) begin
                        nMismatch++;
                        $display("FAIL stall_hold: write=%0b wdata=%h, required write=1 wdata=%h", av.write, av.wdata, prevWdata);
                    end
                end
                prevStall = 1'b0;
                if (done) doneCount++;
                if (av.write) begin
                    if (firstWriteCyc < 0) firstWriteCyc = cyc;
                    nCompared++;
                    if (av.addr !== 2'd1) begin
                        nMismatch++;
                        $display("FAIL write_addr: addr=%0d, required 1", av.addr);
                    end
                    if (stallLeft > 0) begin
                        stallLeft--;
                        av.waitrequest = 1'b1;
                        prevStall = 1'b1;
                        prevWdata = av.wdata;
                    end else begin
                        gotWrites.push_back(av.wdata);
                        if (writeIdx == errWriteIdx) av.resp = 2'b10;
                        writeIdx++;
                        stallLeft = cfgWriteStall;
                    end
                end else if (av.read) begin
                    nCompared++;
                    if (av.addr !== 2'd0) begin
                        nMismatch++;
                        $display("FAIL read_addr: addr=%0d, required 0", av.addr);
                    end
                    readCount++;
                    if (failLeft > 0) begin
                        failLeft--;
                        av.rdata = $urandom() & ~32'h2;
                    end else begin
                        av.rdata = $urandom() | 32'h2;
                        failLeft = cfgFails;
                    end
                end
            end
        end
    end

    function automatic void build_expected(input longint cur, input longint goal, input longint stp);
        expWrites.delete();
        if (stp == 0) stp = 1;
        while (cur != goal) begin
            if (cur < goal) cur = (cur + stp > goal) ? goal : cur + stp;
            else            cur = (cur - stp < goal) ? goal : cur - stp;
            expWrites.push_back(cur[31:0]);
        end
    endfunction

    task automatic arm_slave();
        gotWrites.delete();
        readCount     = 0;
        doneCount     = 0;
        writeIdx      = 0;
        failLeft      = cfgFails;
        stallLeft     = cfgWriteStall;
        firstWriteCyc = -1;
    endtask

    task automatic pulse_start(input logic [31:0] g, input logic [31:0] s, input logic [31:0] iv);
        @(negedge clk);
        freqGoal   = g;
        stepIn     = s;
        intervalIn = iv;
        start      = 1'b1;
        startCyc   = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxCyc);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < maxCyc) begin
            @(negedge clk);
            n++;
            if (!busy && !av.read && !av.write) quiet++;
            else quiet = 0;
        end
        nCompared++;
        if (quiet < 3) begin
            nMismatch++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic wait_write(input int maxCyc);
        int n = 0;
        while (!av.write && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        nCompared++;
        if (!av.write) begin
            nMismatch++;
            $display("FAIL wait_write: no write within %0d cycles, required one", maxCyc);
        end
    endtask

    task automatic run_ramp(input logic [31:0] g, input logic [31:0] s, input logic [31:0] iv);
        arm_slave();
        build_expected(modelFreq, g, s);
        pulse_start(g, s, iv);
        wait_idle(3000);
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        freqGoal = 32'd0; stepIn = 32'd0; intervalIn = 32'd0;
        repeat (3) @(negedge clk);
        nCompared += 4;
        if ({busy, done, error} !== 3'b000) begin
            nMismatch++; $display("FAIL reset_flags: busy/done/error=%b, required 000", {busy, done, error});
        end
        if ({av.read, av.write} !== 2'b00) begin
            nMismatch++; $display("FAIL reset_bus: read/write=%b, required 00", {av.read, av.write});
        end
        if (av.addr !== 2'd0 || av.wdata !== 32'd0) begin
            nMismatch++; $display("FAIL reset_addr_wdata: addr=%0d wdata=%h, required 0 0", av.addr, av.wdata);
        end
        if (freqNow !== 32'd0) begin
            nMismatch++; $display("FAIL reset_freq: freqNow=%h, required 0", freqNow);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_up_ramp();
        int n = 0;
        cfgFails = 0; cfgWriteStall = 0;
        arm_slave();
        build_expected(modelFreq, 1000, 300);
        pulse_start(32'd1000, 32'd300, 32'd4);
        while (gotWrites.size() < 2 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        freqGoal = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; freqGoal = 32'd1000;
        wait_idle(3000);
        nCompared += 5;
        if (firstWriteCyc - startCyc !== 2) begin
            nMismatch++; $display("FAIL up_latency: %0d cycles, required 2", firstWriteCyc - startCyc);
        end
        if (gotWrites.size() !== expWrites.size()) begin
            nMismatch++; $display("FAIL up_count: %0d writes, required %0d", gotWrites.size(), expWrites.size());
        end
        for (int i = 0; i < expWrites.size() && i < gotWrites.size(); i++) begin
            nCompared++;
            if (gotWrites[i] !== expWrites[i]) begin
                nMismatch++; $display("FAIL up_write%0d: %0d, required %0d", i, gotWrites[i], expWrites[i]);
            end
        end
        if (doneCount !== 1) begin
            nMismatch++; $display("FAIL up_done: %0d pulses, required 1", doneCount);
        end
        if (freqNow !== 32'd1000) begin
            nMismatch++; $display("FAIL up_freq: %0d, required 1000", freqNow);
        end
        if (error !== 1'b0) begin
            nMismatch++; $display("FAIL up_error: %0b, required 0", error);
        end
        modelFreq = 1000;
    endtask

    task automatic test_clamps();
        logic [31:0] goals[5] = '{32'd50, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd5};
        logic [31:0] steps[5] = '{32'd400, 32'hFFFFFFFF, 32'h200, 32'd0, 32'hFFFFFFFF};
        for (int k = 0; k < 5; k++) begin
            run_ramp(goals[k], steps[k], 32'd1);
            nCompared += 3;
            if (gotWrites.size() !== expWrites.size()) begin
                nMismatch++; $display("FAIL clamp%0d_count: %0d writes, required %0d", k, gotWrites.size(), expWrites.size());
            end
            for (int i = 0; i < expWrites.size() && i < gotWrites.size(); i++) begin
                nCompared++;
                if (gotWrites[i] !== expWrites[i]) begin
                    nMismatch++; $display("FAIL clamp%0d_write%0d: %h, required %h", k, i, gotWrites[i], expWrites[i]);
                end
            end
            if (freqNow !== goals[k]) begin
                nMismatch++; $display("FAIL clamp%0d_freq: %h, required %h", k, freqNow, goals[k]);
            end
            if (doneCount !== 1 || error !== 1'b0) begin
                nMismatch++; $display("FAIL clamp%0d_status: done=%0d error=%0b, required 1 0", k, doneCount, error);
            end
            modelFreq = goals[k];
        end
    endtask

    task automatic test_random();
        longint      delta;
        longint      g;
        logic [31:0] s;
        for (int it = 0; it < 6; it++) begin
            delta = $urandom_range(1, 20000);
            s = $urandom_range(32'(delta / 8) + 32'd1, 30000);
            if ($urandom_range(0, 1) == 1 && modelFreq + delta <= 64'hFFFFFFFF) g = modelFreq + delta;
            else if (modelFreq >= delta) g = modelFreq - delta;
            else g = modelFreq + delta;
            cfgFails = $urandom_range(0, 4);
            cfgWriteStall = $urandom_range(0, 2);
            run_ramp(g[31:0], s, $urandom_range(0, 5));
            nCompared += 3;
            if (gotWrites.size() !== expWrites.size()) begin
                nMismatch++; $display("FAIL rand%0d_count: %0d writes, required %0d", it, gotWrites.size(), expWrites.size());
            end
            for (int i = 0; i < expWrites.size() && i < gotWrites.size(); i++) begin
                nCompared++;
                if (gotWrites[i] !== expWrites[i]) begin
                    nMismatch++; $display("FAIL rand%0d_write%0d: %h, required %h", it, i, gotWrites[i], expWrites[i]);
                end
            end
            if (freqNow !== g[31:0]) begin
                nMismatch++; $display("FAIL rand%0d_freq: %h, required %h", it, freqNow, g[31:0]);
            end
            if (doneCount !== 1 || error !== 1'b0) begin
                nMismatch++; $display("FAIL rand%0d_status: done=%0d error=%0b, required 1 0", it, doneCount, error);
            end
            modelFreq = g;
        end
        cfgFails = 0; cfgWriteStall = 0;
    endtask

    task automatic test_poll_timeout();
        cfgFails = 100;
        run_ramp(modelFreq[31:0] + 32'd1000, 32'd300, 32'd0);
        nCompared += 4;
        if (readCount !== 8) begin
            nMismatch++; $display("FAIL timeout_reads: %0d, required 8", readCount);
        end
        if (error !== 1'b1 || busy !== 1'b0) begin
            nMismatch++; $display("FAIL timeout_status: error=%0b busy=%0b, required 1 0", error, busy);
        end
        if (freqNow !== modelFreq[31:0]) begin
            nMismatch++; $display("FAIL timeout_freq: %h, required %h", freqNow, modelFreq[31:0]);
        end
        if (doneCount !== 0) begin
            nMismatch++; $display("FAIL timeout_done: %0d, required 0", doneCount);
        end
        cfgFails = 0;
    endtask

    task automatic test_error_resp();
        longint first;
        first = modelFreq + 300;
        errWriteIdx = 1;
        run_ramp(modelFreq[31:0] + 32'd1000, 32'd300, 32'd2);
        errWriteIdx = -1;
        nCompared += 3;
        if (gotWrites.size() !== 2) begin
            nMismatch++; $display("FAIL resp_count: %0d writes, required 2", gotWrites.size());
        end
        if (error !== 1'b1 || doneCount !== 0) begin
            nMismatch++; $display("FAIL resp_status: error=%0b done=%0d, required 1 0", error, doneCount);
        end
        if (freqNow !== first[31:0]) begin
            nMismatch++; $display("FAIL resp_freq: %h, required %h", freqNow, first[31:0]);
        end
        modelFreq = first;
        run_ramp(modelFreq[31:0], 32'd5, 32'd0);
        nCompared += 2;
        if (error !== 1'b0) begin
            nMismatch++; $display("FAIL resp_clear: error=%0b, required 0", error);
        end
        if (doneCount !== 1 || gotWrites.size() !== 0) begin
            nMismatch++; $display("FAIL resp_same_goal: done=%0d writes=%0d, required 1 0", doneCount, gotWrites.size());
        end
    endtask

    task automatic test_abort_stall();
        cfgWriteStall = 3;
        arm_slave();
        pulse_start(modelFreq[31:0] + 32'd5000, 32'd1000, 32'd0);
        wait_write(20);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (25) @(negedge clk);
        cfgWriteStall = 0;
        nCompared += 4;
        if (gotWrites.size() !== 1 || readCount !== 0) begin
            nMismatch++; $display("FAIL abort_xfers: writes=%0d reads=%0d, required 1 0", gotWrites.size(), readCount);
        end
        if (doneCount !== 0) begin
            nMismatch++; $display("FAIL abort_done: %0d, required 0", doneCount);
        end
        if (busy !== 1'b0 || error !== 1'b0) begin
            nMismatch++; $display("FAIL abort_status: busy=%0b error=%0b, required 0 0", busy, error);
        end
        if (freqNow !== modelFreq[31:0]) begin
            nMismatch++; $display("FAIL abort_freq: %h, required %h", freqNow, modelFreq[31:0]);
        end
    endtask

    task automatic test_start_with_abort();
        int busySeen = 0;
        arm_slave();
        @(negedge clk);
        freqGoal = modelFreq[31:0] + 32'd100; stepIn = 32'd10; intervalIn = 32'd0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busySeen++;
            @(negedge clk);
        end
        nCompared += 2;
        if (busySeen !== 0 || gotWrites.size() !== 0) begin
            nMismatch++; $display("FAIL start_abort: busy_cycles=%0d writes=%0d, required 0 0", busySeen, gotWrites.size());
        end
        if (doneCount !== 0) begin
            nMismatch++; $display("FAIL start_abort_done: %0d, required 0", doneCount);
        end
    endtask

    task automatic test_reset_mid();
        cfgWriteStall = 5;
        arm_slave();
        pulse_start(modelFreq[31:0] + 32'd500, 32'd100, 32'd0);
        wait_write(20);
        rstn = 1'b0;
        @(negedge clk);
        nCompared += 2;
        if ({av.read, av.write} !== 2'b00 || busy !== 1'b0) begin
            nMismatch++; $display("FAIL reset_mid_bus: read/write=%b busy=%0b, required 00 0", {av.read, av.write}, busy);
        end
        if (freqNow !== 32'd0) begin
            nMismatch++; $display("FAIL reset_mid_freq: %h, required 0", freqNow);
        end
        rstn = 1'b1;
        cfgWriteStall = 0;
        modelFreq = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_clamps();
        test_random();
        test_poll_timeout();
        test_error_resp();
        test_abort_stall();
        test_start_with_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/mbldcm_ramp_master.md
Name: mbldcm_ramp_master

Overview:
- Avalon-MM master that sits directly upstream of the BLDC motor controller's slave interface.
- Ramps the commanded commutation frequency from its current value toward a goal value, one step per programmable interval.
- Each step writes the frequency-target register, then polls the status register until the controller reports the new frequency as reflected.
- Provides soft-start and soft-stop, so software no longer has to pace frequency writes.

Parameters:
- pFreqAddr, 2'd1, word address of the frequency-target register in the controller.
- pStatAddr, 2'd0, word address of the status register in the controller.
- pReflBit, 5'd1, bit index of "frequency reflected" in the status read data.
- pPollLimit, 32'd1024, maximum poll reads per step before error.

Ports:
- iClock  in  1  system clock.
- iReset_n  in  1  synchronous active-low reset.
- iStart  in  1  one-cycle pulse; latch goal, step and interval, then begin ramp. Ignored while busy.
- iAbort  in  1  one-cycle pulse; stop after the current bus transfer completes, return to IDLE. oFreqNow is held.
- iFreqGoal  in  32  target frequency (controller units).
- iStep  in  32  frequency increment per step. 0 is treated as 1.
- iInterval  in  32  clock cycles waited between steps. 0 means no wait.
- oBusy  out  1  high from the cycle after accepted iStart until IDLE, DONE or ERR.
- oDone  out  1  one-cycle pulse when oFreqNow == goal and reflected.
- oError  out  1  sticky; set on nonzero iResp or poll timeout; cleared by the next accepted iStart.
- oFreqNow  out  32  last frequency confirmed reflected.
- oAddr  out  2  Avalon address.
- oRead  out  1  Avalon read.
- oWrite  out  1  Avalon write.
- oWdata  out  32  Avalon write data.
- iRdata  in  32  Avalon read data.
- iResp  in  2  Avalon response; 2'b00 = OK.
- iWaitrequest  in  1  Avalon waitrequest; tie 0 for the zero-wait controller.

Behaviour:
- Reset (iReset_n low at a rising edge):
  - State = IDLE.
  - oBusy, oDone, oError, oRead, oWrite = 0.
  - oAddr = 0, oWdata = 0, oFreqNow = 0, counters = 0.
- FSM states: IDLE, WAIT, CALC, WRITE, POLL, DONE, ERR.
- IDLE:
  - On iStart: latch goal/step/interval, clear oError.
  - If goal == oFreqNow, go to DONE; otherwise go to CALC.
- CALC (1 cycle):
  - If oFreqNow < goal: next = oFreqNow + step, clamped to goal. The add is 33-bit; overflow clamps to goal.
  - Else: next = oFreqNow - step, clamped to goal. The subtract is 33-bit; underflow clamps to goal.
  - Go to WRITE.
- WRITE:
  - Drive oWrite=1, oAddr=pFreqAddr, oWdata=next.
  - Hold all three while iWaitrequest=1. The transfer completes on the first cycle with iWaitrequest=0.
  - On completion, iResp != 0 goes to ERR; otherwise clear the poll counter and go to POLL.
- POLL:
  - Drive oRead=1, oAddr=pStatAddr.
  - iRdata and iResp are sampled in the completion cycle.
  - If iRdata[pReflBit]=1: oFreqNow <= next. Go to DONE if next == goal, else load the interval counter and go to WAIT.
  - If iRdata[pReflBit]=0: increment the poll counter, deassert oRead for one cycle, re-issue the read.
  - Poll counter reaching pPollLimit goes to ERR.
  - iResp != 0 goes to ERR.
- WAIT:
  - Count down the interval. At 0 go to CALC; an interval of 0 goes to CALC on the next cycle.
- DONE:
  - oDone=1 for exactly one cycle, then IDLE.
- ERR:
  - oError <= 1, then IDLE. oFreqNow keeps the last confirmed value.
- Bus rules:
  - oRead and oWrite are never high together.
  - Both are registered outputs, with no combinational path from inputs.
- iAbort:
  - In WAIT, CALC or IDLE: takes effect next cycle (to IDLE).
  - In WRITE or POLL: registered, and applied when the current transfer completes (to IDLE). No oDone is produced.
- iStart while busy is ignored. iStart and iAbort together in IDLE: the abort wins and nothing starts.
- Reset mid-transfer forces oRead and oWrite to 0 in the same edge and drops all state.
- Latency, zero-wait slave, reflected on the first poll: iStart to the first oWrite is 2 cycles (IDLE, CALC).

Test Plan:
- Up-ramp: oFreqNow=0, goal=1000, step=300, interval=4, slave reflects immediately -> writes 300, 600, 900, 1000; oDone once; oFreqNow=1000; oError=0.
- Down-ramp with clamp: from 1000, goal=50, step=400 -> writes 600, 200, 50; oDone; no underflow wrap.
- Overflow clamp: oFreqNow=32'hFFFFFF00, goal=32'hFFFFFFFF, step=32'h200 -> single write of 32'hFFFFFFFF.
- Poll timeout: reflected bit held 0, pPollLimit=8 -> 8 reads, oError=1, oBusy=0, oFreqNow unchanged.
- Error response: iResp=2'b10 on the second write -> ERR; oFreqNow equals the first step value; a new iStart clears oError.
- Abort and waitrequest: iWaitrequest=1 for 3 cycles during a write with iAbort pulsed mid-stall -> oWrite and oWdata held stable, no further transfers after completion, IDLE, no oDone.
